// File: rtl/ce_tx_arb_pkg.sv
// Shared types and helpers for the copy-engine TX round-robin arbiter.
package ce_tx_arb_pkg;

  typedef enum logic {IDLE, XFER} t_arb_state;

  // Channel index width sized for the largest supported channel count.
  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = $clog2(MAX_CH);

  // First requester at or after ptr in circular order over num_ch channels.
  function automatic logic [CH_IDX_W-1:0] rr_pick(input logic [MAX_CH-1:0]   req,
                                                  input logic [CH_IDX_W-1:0] ptr,
                                                  input int                  num_ch);
    logic [CH_IDX_W-1:0] pick;
    logic [CH_IDX_W:0]   sum;
    logic                found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < num_ch) begin
        sum = {1'b0, ptr} + (CH_IDX_W+1)'(i);
        if (sum >= (CH_IDX_W+1)'(num_ch)) sum = sum - (CH_IDX_W+1)'(num_ch);
        if (!found && req[sum[CH_IDX_W-1:0]]) begin
          pick  = sum[CH_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ce_axis_skid_reg.sv
// Two-entry AXI-S skid buffer: outputs come straight from registers, input
// ready depends only on local state, one beat per cycle sustained.
module ce_axis_skid_reg #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W/8,
  parameter int USER_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [USER_W-1:0] in_user,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic [USER_W-1:0] out_user,
  output logic              out_last
);
  localparam int PL_W = DATA_W + KEEP_W + USER_W + 1;

  logic [PL_W-1:0] in_pl, out_pl, skid_pl;
  logic            skid_valid, push, out_free;

  assign in_pl    = {in_data, in_keep, in_user, in_last};
  assign {out_data, out_keep, out_user, out_last} = out_pl;

  // The skid entry is only ever occupied while the output entry is too.
  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // NOTE: non-blocking assignments on every flop so all registers update from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_pl     <= '0;
    end else if (out_free) begin
      out_valid  <= skid_valid || push;
      skid_valid <= 1'b0;
      if (skid_valid) out_pl <= skid_pl;
      else if (push)  out_pl <= in_pl;
    end else if (push) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload has no reset; skid_valid qualifies it, so clearing
  // it would only add reset fan-out on a wide bus.
  always_ff @(posedge clk) begin
    if (push && !out_free) skid_pl <= in_pl;
  end

endmodule

// File: rtl/ce_axis_tx_arb.sv
// Packet-atomic round-robin merge of NUM_CH AXI-S TX sources onto one link.
// Define CE_TX_ARB_PERF_CNT_EN to add per-channel packet counters.
module ce_axis_tx_arb
  import ce_tx_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 512,
  parameter int USER_W = 10,
  parameter int KEEP_W = DATA_W/8,
  parameter int QUOTA  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          s_tvalid,
  output logic [NUM_CH-1:0]          s_tready,
  input  logic [NUM_CH*DATA_W-1:0]   s_tdata,
  input  logic [NUM_CH*KEEP_W-1:0]   s_tkeep,
  input  logic [NUM_CH*USER_W-1:0]   s_tuser,
  input  logic [NUM_CH-1:0]          s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic [KEEP_W-1:0]          m_tkeep,
  output logic [USER_W-1:0]          m_tuser,
  output logic                       m_tlast,
  output logic [$clog2(NUM_CH)-1:0]  grant_ch
`ifdef CE_TX_ARB_PERF_CNT_EN
  ,
  output logic [NUM_CH*32-1:0]       perf_pkt_cnt
`endif
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int QCNT_W = 4;

  t_arb_state          state, state_nxt;
  logic [CH_W-1:0]     rr_ptr, rr_ptr_nxt, grant_nxt, next_ch;
  logic [QCNT_W-1:0]   qcnt, qcnt_nxt;
  logic                at_bound, at_bound_nxt;
  logic                skid_ready, in_valid, in_fire, in_last;
  logic [DATA_W-1:0]   in_data;
  logic [KEEP_W-1:0]   in_keep;
  logic [USER_W-1:0]   in_user;
  logic [MAX_CH-1:0]   req_pad;
  logic [CH_IDX_W-1:0] pick;

  // Only the granted channel is ever steered into the output stage.
  always_comb begin
    in_valid = (state == XFER) && s_tvalid[grant_ch];
    in_data  = s_tdata[grant_ch*DATA_W +: DATA_W];
    in_keep  = s_tkeep[grant_ch*KEEP_W +: KEEP_W];
    in_user  = s_tuser[grant_ch*USER_W +: USER_W];
    in_last  = s_tlast[grant_ch];
    s_tready = '0;
    if (state == XFER) s_tready[grant_ch] = skid_ready;
  end

  assign in_fire = in_valid && skid_ready;
  assign next_ch = (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + 1'b1;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_ch;
    rr_ptr_nxt   = rr_ptr;
    qcnt_nxt     = qcnt;
    at_bound_nxt = at_bound;
    req_pad      = '0;
    req_pad[NUM_CH-1:0] = s_tvalid;
    pick         = rr_pick(req_pad, CH_IDX_W'(rr_ptr), NUM_CH);
    case (state)
      IDLE: begin
        if (|s_tvalid) begin
          grant_nxt    = CH_W'(pick);
          qcnt_nxt     = '0;
          at_bound_nxt = 1'b0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        if (in_fire) begin
          at_bound_nxt = 1'b0;
          if (in_last) begin
            qcnt_nxt = qcnt + 1'b1;
            if ((qcnt + 1'b1) == QCNT_W'(QUOTA)) begin
              state_nxt  = IDLE;
              rr_ptr_nxt = next_ch;
            end else begin
              at_bound_nxt = 1'b1;
            end
          end
        end else if (at_bound && !s_tvalid[grant_ch]) begin
          // Quota not used up but the owner has nothing queued: hand over.
          state_nxt  = IDLE;
          rr_ptr_nxt = next_ch;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_ch <= '0;
      rr_ptr   <= '0;
      qcnt     <= '0;
      at_bound <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_ch <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      qcnt     <= qcnt_nxt;
      at_bound <= at_bound_nxt;
    end
  end

  ce_axis_skid_reg #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (skid_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_user   (in_user),
    .in_last   (in_last),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .out_data  (m_tdata),
    .out_keep  (m_tkeep),
    .out_user  (m_tuser),
    .out_last  (m_tlast)
  );

`ifdef CE_TX_ARB_PERF_CNT_EN
  logic [31:0] pkt_cnt [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) pkt_cnt[i] <= '0;
    end else if (in_fire && in_last) begin
      pkt_cnt[grant_ch] <= pkt_cnt[grant_ch] + 32'd1;
    end
  end

  always_comb begin
    perf_pkt_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) perf_pkt_cnt[i*32 +: 32] = pkt_cnt[i];
  end
`else
  // Counters compiled out; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_ce_axis_tx_arb.sv
// Scoreboard bench for ce_axis_tx_arb: dut0 runs QUOTA=1, dut1 runs QUOTA=3.
module tb_ce_axis_tx_arb;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int KW  = DW/8;
  localparam int UW  = 10;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]    s_tvalid [2];
  logic [NCH-1:0]    s_tready [2];
  logic [NCH-1:0]    s_tlast  [2];
  logic [NCH*DW-1:0] s_tdata  [2];
  logic [NCH*KW-1:0] s_tkeep  [2];
  logic [NCH*UW-1:0] s_tuser  [2];
  logic              m_tvalid [2];
  logic              m_tready [2];
  logic              m_tlast  [2];
  logic [DW-1:0]     m_tdata  [2];
  logic [KW-1:0]     m_tkeep  [2];
  logic [UW-1:0]     m_tuser  [2];
  logic [1:0]        grant_ch [2];
`ifdef CE_TX_ARB_PERF_CNT_EN
  logic [NCH*32-1:0] perf_pkt_cnt [2];
`endif

  ce_axis_tx_arb #(.NUM_CH(NCH), .DATA_W(DW), .USER_W(UW), .KEEP_W(KW), .QUOTA(1)) dut0 (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]),
    .s_tkeep(s_tkeep[0]), .s_tuser(s_tuser[0]), .s_tlast(s_tlast[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]),
    .m_tkeep(m_tkeep[0]), .m_tuser(m_tuser[0]), .m_tlast(m_tlast[0]),
    .grant_ch(grant_ch[0])
`ifdef CE_TX_ARB_PERF_CNT_EN
    , .perf_pkt_cnt(perf_pkt_cnt[0])
`endif
  );

  ce_axis_tx_arb #(.NUM_CH(NCH), .DATA_W(DW), .USER_W(UW), .KEEP_W(KW), .QUOTA(3)) dut1 (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]),
    .s_tkeep(s_tkeep[1]), .s_tuser(s_tuser[1]), .s_tlast(s_tlast[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]),
    .m_tkeep(m_tkeep[1]), .m_tuser(m_tuser[1]), .m_tlast(m_tlast[1]),
    .grant_ch(grant_ch[1])
`ifdef CE_TX_ARB_PERF_CNT_EN
    , .perf_pkt_cnt(perf_pkt_cnt[1])
`endif
  );

  beat_t src_q [2*NCH][$];
  beat_t exp_q [2][$];
  int    tready_mode [2];   // 0 = low, 1 = high, 2 = toggle every cycle
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat encoding: data = {dut, ch, pkt, beat}; short keep on the last beat.
  function automatic beat_t mk(input int d, input int c, input int p, input int b, input int n);
    beat_t x;
    x.data = {8'(d), 8'(c), 8'(p), 8'(b)};
    x.keep = (b == n-1) ? 4'h3 : 4'hF;
    x.user = UW'(c*16 + p);
    x.last = (b == n-1);
    x.gap  = 0;
    return x;
  endfunction

  function automatic logic [63:0] pl_of(input beat_t x);
    return 64'({x.data, x.keep, x.user, x.last});
  endfunction

  task automatic send(input int d, input int c, input int p, input int n,
                      input int gap_beat, input int gap);
    beat_t x;
    for (int b = 0; b < n; b++) begin
      x = mk(d, c, p, b, n);
      if (b == gap_beat) x.gap = gap;
      src_q[d*NCH + c].push_back(x);
    end
  endtask

  task automatic expect_pkt(input int d, input int c, input int p, input int n);
    for (int b = 0; b < n; b++) exp_q[d].push_back(mk(d, c, p, b, n));
  endtask

  task automatic wait_drain(input int d, input string name);
    for (int k = 0; k < 3000; k++) begin
      if (exp_q[d].size() == 0) break;
      @(negedge clk);
    end
    check(name, 64'(exp_q[d].size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Source driver: the handshake is decided at the negedge, applied after the edge.
  initial begin
    logic [NCH-1:0] fire [2];
    beat_t          b;
    int             k;
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = '0; s_tlast[d] = '0; s_tdata[d] = '0;
      s_tkeep[d]  = '0; s_tuser[d] = '0; m_tready[d] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) fire[d] = s_tvalid[d] & s_tready[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        case (tready_mode[d])
          0:       m_tready[d] = 1'b0;
          2:       m_tready[d] = ~m_tready[d];
          default: m_tready[d] = 1'b1;
        endcase
        for (int c = 0; c < NCH; c++) begin
          k = d*NCH + c;
          if (fire[d][c] && src_q[k].size() > 0) void'(src_q[k].pop_front());
          if (src_q[k].size() > 0 && src_q[k][0].gap > 0) begin
            b = src_q[k][0];
            b.gap = b.gap - 1;
            src_q[k][0] = b;
            s_tvalid[d][c] = 1'b0;
          end else if (src_q[k].size() > 0) begin
            b = src_q[k][0];
            s_tvalid[d][c]          = 1'b1;
            s_tdata[d][c*DW +: DW]  = b.data;
            s_tkeep[d][c*KW +: KW]  = b.keep;
            s_tuser[d][c*UW +: UW]  = b.user;
            s_tlast[d][c]           = b.last;
          end else begin
            s_tvalid[d][c] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin
    logic        hold_v  [2];
    logic [63:0] hold_pl [2];
    logic [63:0] act;
    beat_t       e;
    hold_v[0] = 1'b0; hold_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        act = 64'({m_tdata[d], m_tkeep[d], m_tuser[d], m_tlast[d]});
        if (rst) begin
          hold_v[d] = 1'b0;
        end else begin
          if (hold_v[d]) begin
            check($sformatf("d%0d_stall_valid", d), 64'(m_tvalid[d]), 64'd1);
            check($sformatf("d%0d_stall_payload", d), act, hold_pl[d]);
          end
          if (m_tvalid[d] && m_tready[d]) begin
            if (exp_q[d].size() == 0) begin
              check($sformatf("d%0d_unexpected_beat_q", d), 64'(exp_q[d].size()), 64'd1);
            end else begin
              e = exp_q[d].pop_front();
              check($sformatf("d%0d_beat", d), act, pl_of(e));
            end
          end
          hold_v[d]  = m_tvalid[d] && !m_tready[d];
          hold_pl[d] = act;
        end
      end
    end
  end

  initial begin
    beat_t ref_b;
    int    found;
    int    left;
    tready_mode[0] = 1;
    tready_mode[1] = 1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("rst_s_tready", 64'(s_tready[0]), 64'd0);
    check("rst_grant",    64'(grant_ch[0]), 64'd0);
    check("rst_m_tdata",  64'(m_tdata[0]), 64'd0);
    check("rst_m_tvalid1", 64'(m_tvalid[1]), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness, QUOTA=1: two 3-beat packets queued on every channel
    for (int c = 0; c < NCH; c++) begin
      send(0, c, 0, 3, -1, 0);
      send(0, c, 1, 3, -1, 0);
    end
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NCH; c++) expect_pkt(0, c, p, 3);
    wait_drain(0, "fair_drain");

    // Mid-packet stall: ch0 pauses before beat 2, ch1 must wait for ch0's tlast
    send(0, 0, 2, 4, 2, 6);
    send(0, 1, 2, 2, -1, 0);
    expect_pkt(0, 0, 2, 4);
    expect_pkt(0, 1, 2, 2);
    wait_drain(0, "stall_drain");

    // Backpressure: m_tready toggles during an 8-beat packet
    tready_mode[0] = 2;
    send(0, 2, 3, 8, -1, 0);
    expect_pkt(0, 2, 3, 8);
    wait_drain(0, "bp_drain");
    tready_mode[0] = 1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a stalled ch1 packet
    tready_mode[0] = 0;
    send(0, 1, 4, 4, -1, 0);
    expect_pkt(0, 1, 4, 4);
    repeat (6) @(negedge clk);
    check("pre_rst_grant",    64'(grant_ch[0]), 64'd1);
    check("pre_rst_m_tvalid", 64'(m_tvalid[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("midrst_s_tready", 64'(s_tready[0]), 64'd0);
    check("midrst_grant",    64'(grant_ch[0]), 64'd0);
    for (int k = 0; k < 2*NCH; k++) src_q[k].delete();
    exp_q[0].delete();
    exp_q[1].delete();
    tready_mode[0] = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // First request after reset on ch2: data one cycle after acceptance
    send(0, 2, 0, 1, -1, 0);
    expect_pkt(0, 2, 0, 1);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_tvalid[0][2] && s_tready[0][2]) begin
        found = 1;
        break;
      end
    end
    check("ch2_accept_seen", 64'(found), 64'd1);
    if (found == 1) begin
      @(negedge clk);
      ref_b = mk(0, 2, 0, 0, 1);
      check("lat_m_tvalid", 64'(m_tvalid[0]), 64'd1);
      check("lat_m_tdata",  64'(m_tdata[0]), 64'(ref_b.data));
      check("lat_grant",    64'(grant_ch[0]), 64'd2);
    end
    wait_drain(0, "rst_drain");

`ifdef CE_TX_ARB_PERF_CNT_EN
    // Four more ch2 packets and two ch0 packets; pointer sits at 3
    for (int p = 1; p <= 4; p++) send(0, 2, p, 2, -1, 0);
    send(0, 0, 1, 1, -1, 0);
    send(0, 0, 2, 1, -1, 0);
    expect_pkt(0, 0, 1, 1);
    expect_pkt(0, 2, 1, 2);
    expect_pkt(0, 0, 2, 1);
    expect_pkt(0, 2, 2, 2);
    expect_pkt(0, 2, 3, 2);
    expect_pkt(0, 2, 4, 2);
    wait_drain(0, "perf_drain");
    check("perf_ch0", 64'(perf_pkt_cnt[0][0*32 +: 32]), 64'd2);
    check("perf_ch1", 64'(perf_pkt_cnt[0][1*32 +: 32]), 64'd0);
    check("perf_ch2", 64'(perf_pkt_cnt[0][2*32 +: 32]), 64'd5);
    check("perf_ch3", 64'(perf_pkt_cnt[0][3*32 +: 32]), 64'd0);
`endif

    // Quota=3 on dut1: ch1 and ch3 compete
    for (int p = 0; p < 6; p++) send(1, 1, p, 2, -1, 0);
    for (int p = 0; p < 4; p++) send(1, 3, p, 2, -1, 0);
    for (int p = 0; p < 3; p++) expect_pkt(1, 1, p, 2);
    for (int p = 0; p < 3; p++) expect_pkt(1, 3, p, 2);
    for (int p = 3; p < 6; p++) expect_pkt(1, 1, p, 2);
    expect_pkt(1, 3, 3, 2);
    wait_drain(1, "quota_drain");

    // ch3 ran dry below quota, so the pointer moved on to ch0 and ch1 wins next
    send(1, 3, 4, 2, -1, 0);
    send(1, 1, 6, 2, -1, 0);
    expect_pkt(1, 1, 6, 2);
    expect_pkt(1, 3, 4, 2);
    wait_drain(1, "handover_drain");

    left = 0;
    for (int k = 0; k < 2*NCH; k++) left += src_q[k].size();
    check("src_empty", 64'(left), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
